// File: rtl/reg_universal_n_pkg.sv
// Shared mode and FSM state encodings for the universal register.
// Imported by the RTL and by the bench.
package reg_universal_n_pkg;

  typedef enum logic [2:0] {
    M_HOLD = 3'd0,
    M_LOAD = 3'd1,
    M_SHL  = 3'd2,
    M_SHR  = 3'd3,
    M_ROL  = 3'd4,
    M_ROR  = 3'd5,
    M_ASR  = 3'd6,
    M_CLR  = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/reg_universal_n_cell.sv
// One bit slice of the universal register: 8:1 next-value mux
// plus a flop with synchronous reset and clock enable.
module reg_universal_n_cell
  import reg_universal_n_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [2:0] op_i,
  input  logic       d_i,
  input  logic       lnb_i,
  input  logic       rnb_i,
  output logic       q_o
);

  logic q_q;
  logic q_d;

  // lnb_i feeds left moves, rnb_i feeds right moves
  always_comb begin
    q_d = q_q;
    unique case (mode_e'(op_i))
      M_HOLD: q_d = q_q;
      M_LOAD: q_d = d_i;
      M_SHL:  q_d = lnb_i;
      M_ROL:  q_d = lnb_i;
      M_SHR:  q_d = rnb_i;
      M_ROR:  q_d = rnb_i;
      M_ASR:  q_d = rnb_i;
      M_CLR:  q_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else if (en_i) begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/reg_universal_n.sv
// WIDTH-bit universal register with a repeat-op FSM
// (start/cnt run one shift or rotate cnt times).
module reg_universal_n
  import reg_universal_n_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  mode_e            mode_q;

  mode_e            op;
  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] lnb;
  logic [WIDTH-1:0] rnb;
  logic             lsb_src;
  logic             msb_src;

  // The start edge itself and the DONE cycle leave q alone
  always_comb begin
    op = M_HOLD;
    unique case (state_q)
      S_IDLE:  op = start ? M_HOLD : mode_e'(mode);
      S_BUSY:  op = mode_q;
      S_DONE:  op = M_HOLD;
      default: op = M_HOLD;
    endcase
  end

  always_comb begin
    lsb_src = sin_r;
    if (op == M_ROL) begin
      lsb_src = q_w[WIDTH-1];
    end
  end

  always_comb begin
    msb_src = sin_l;
    if (op == M_ROR) begin
      msb_src = q_w[0];
    end else if (op == M_ASR) begin
      msb_src = q_w[WIDTH-1];
    end
  end

  assign lnb = {q_w[WIDTH-2:0], lsb_src};
  assign rnb = {msb_src, q_w[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    reg_universal_n_cell u_cell (
      .clk   (clk),
      .rst   (rst),
      .en_i  (en),
      .op_i  (op),
      .d_i   (d[i]),
      .lnb_i (lnb[i]),
      .rnb_i (rnb[i]),
      .q_o   (q_w[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= M_HOLD;
    end else if (en) begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q  <= mode_e'(mode);
            cnt_q   <= cnt;
            state_q <= (cnt != '0) ? S_BUSY : S_DONE;
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign q      = q_w;
  assign sout_l = q_w[WIDTH-1];
  assign sout_r = q_w[0];
  assign busy   = (state_q == S_BUSY);
  assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_reg_universal_n.sv
// Directed bench for reg_universal_n (WIDTH=8, CNT_W=4).
module tb_reg_universal_n;
  import reg_universal_n_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin_l;
  logic       sin_r;
  logic       start;
  logic [3:0] cnt;
  logic [7:0] q;
  logic       sout_l;
  logic       sout_r;
  logic       busy;
  logic       done;

  int errs;
  int checks;

  reg_universal_n #(.WIDTH(8), .CNT_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .d      (d),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .start  (start),
    .cnt    (cnt),
    .q      (q),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    mode = M_LOAD;
    d    = v;
    tick();
    mode = M_HOLD;
  endtask

  // Pulse start and wait (bounded) for done; caller checks the outcome
  task automatic run_rep(input mode_e m, input logic [3:0] c,
                         output bit got_done);
    got_done = 1'b0;
    mode  = m;
    cnt   = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode  = M_HOLD;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mode = 3'($urandom_range(0, 7));
      d    = 8'($urandom);
      tick();
    end
    rst  = 1'b0;
    mode = M_HOLD;
    checks++;
    if (q !== 8'h00) begin
      errs++;
      $display("FAIL reset_q got=%h exp=00", q);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL reset_flags got=%b%b exp=00", busy, done);
    end
  endtask

  task automatic test_load_shl;
    do_load(8'hA5);
    checks++;
    if (q !== 8'hA5 || sout_l !== 1'b1 || sout_r !== 1'b1) begin
      errs++;
      $display("FAIL load got=%h sl=%b sr=%b exp=a5 1 1",
               q, sout_l, sout_r);
    end
    mode  = M_SHL;
    sin_r = 1'b1;
    tick();
    mode  = M_HOLD;
    sin_r = 1'b0;
    checks++;
    if (q !== 8'h4B) begin
      errs++;
      $display("FAIL shl got=%h exp=4b", q);
    end
  endtask

  task automatic test_rol_rep;
    logic [7:0] exp_q [3];
    exp_q[0] = 8'h03;
    exp_q[1] = 8'h06;
    exp_q[2] = 8'h0C;
    do_load(8'h81);
    mode  = M_ROL;
    cnt   = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode  = M_HOLD;
    checks++;
    if (q !== 8'h81 || busy !== 1'b1) begin
      errs++;
      $display("FAIL rol_start got=%h b=%b exp=81 1", q, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q !== exp_q[i] || busy !== (i < 2) || done !== (i == 2)) begin
        errs++;
        $display("FAIL rol_step%0d got=%h b=%b dn=%b exp=%h",
                 i, q, busy, done, exp_q[i]);
      end
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h0C) begin
      errs++;
      $display("FAIL rol_idle got=%h b=%b dn=%b exp=0c 0 0",
               q, busy, done);
    end
  endtask

  task automatic test_single_ops;
    do_load(8'h80);
    mode = M_ASR;
    tick();
    checks++;
    if (q !== 8'hC0) begin
      errs++;
      $display("FAIL asr got=%h exp=c0", q);
    end
    do_load(8'h80);
    mode  = M_SHR;
    sin_l = 1'b0;
    tick();
    checks++;
    if (q !== 8'h40) begin
      errs++;
      $display("FAIL shr got=%h exp=40", q);
    end
    do_load(8'h01);
    mode = M_ROR;
    tick();
    checks++;
    if (q !== 8'h80) begin
      errs++;
      $display("FAIL ror got=%h exp=80", q);
    end
    mode = M_CLR;
    tick();
    mode = M_HOLD;
    checks++;
    if (q !== 8'h00) begin
      errs++;
      $display("FAIL clr got=%h exp=00", q);
    end
  endtask

  task automatic test_cnt0_and_drop;
    do_load(8'h0C);
    mode  = M_SHL;
    cnt   = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode  = M_HOLD;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h0C) begin
      errs++;
      $display("FAIL cnt0 got=%h b=%b dn=%b exp=0c 0 1", q, busy, done);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errs++;
      $display("FAIL cnt0_pulse dn=%b exp=0", done);
    end
    do_load(8'h01);
    sin_r = 1'b0;
    mode  = M_SHL;
    cnt   = 4'd2;
    start = 1'b1;
    tick();
    mode  = M_CLR;
    d     = 8'hFF;
    cnt   = 4'd5;
    tick();
    start = 1'b0;
    mode  = M_HOLD;
    checks++;
    if (q !== 8'h02 || busy !== 1'b1) begin
      errs++;
      $display("FAIL drop_mid got=%h b=%b exp=02 1", q, busy);
    end
    tick();
    checks++;
    if (q !== 8'h04 || done !== 1'b1) begin
      errs++;
      $display("FAIL drop_end got=%h dn=%b exp=04 1", q, done);
    end
    tick();
    checks++;
    if (q !== 8'h04 || busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL drop_idle got=%h b=%b dn=%b exp=04 0 0",
               q, busy, done);
    end
  endtask

  task automatic test_wide_counts;
    bit ok;
    do_load(8'hA5);
    run_rep(M_ROL, 4'd8, ok);
    checks++;
    if (!ok || q !== 8'hA5) begin
      errs++;
      $display("FAIL rol8 got=%h done=%b exp=a5 1", q, ok);
    end
    do_load(8'h00);
    sin_l = 1'b1;
    run_rep(M_SHR, 4'd9, ok);
    sin_l = 1'b0;
    checks++;
    if (!ok || q !== 8'hFF) begin
      errs++;
      $display("FAIL shr9 got=%h done=%b exp=ff 1", q, ok);
    end
    do_load(8'h80);
    run_rep(M_ASR, 4'd15, ok);
    checks++;
    if (!ok || q !== 8'hFF) begin
      errs++;
      $display("FAIL asr15 got=%h done=%b exp=ff 1", q, ok);
    end
  endtask

  task automatic test_rst_abort;
    do_load(8'hFF);
    sin_r = 1'b0;
    mode  = M_SHL;
    cnt   = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode  = M_HOLD;
    tick();
    tick();
    checks++;
    if (q !== 8'hFC || busy !== 1'b1) begin
      errs++;
      $display("FAIL abort_pre got=%h b=%b exp=fc 1", q, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL abort_rst got=%h b=%b dn=%b exp=00 0 0",
               q, busy, done);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h00) begin
      errs++;
      $display("FAIL abort_after got=%h b=%b dn=%b exp=00 0 0",
               q, busy, done);
    end
  endtask

  task automatic test_en_freeze;
    do_load(8'h01);
    mode  = M_ROL;
    cnt   = 4'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode  = M_LOAD;
    d     = 8'h5A;
    tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q !== 8'h02 || busy !== 1'b1) begin
        errs++;
        $display("FAIL freeze%0d got=%h b=%b exp=02 1", i, q, busy);
      end
    end
    en = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (q !== 8'h10 || done !== 1'b1) begin
      errs++;
      $display("FAIL resume got=%h dn=%b exp=10 1", q, done);
    end
    en = 1'b0;
    tick();
    checks++;
    if (done !== 1'b1) begin
      errs++;
      $display("FAIL done_hold dn=%b exp=1", done);
    end
    mode = M_HOLD;
    en   = 1'b1;
    tick();
    checks++;
    if (done !== 1'b0 || q !== 8'h10) begin
      errs++;
      $display("FAIL done_clear got=%h dn=%b exp=10 0", q, done);
    end
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    rst    = 1'b1;
    en     = 1'b1;
    mode   = M_HOLD;
    d      = 8'h00;
    sin_l  = 1'b0;
    sin_r  = 1'b0;
    start  = 1'b0;
    cnt    = 4'd0;
    test_reset();
    test_load_shl();
    test_rol_rep();
    test_single_ops();
    test_cnt0_and_drop();
    test_wide_counts();
    test_rst_abort();
    test_en_freeze();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
